// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, reset PC and FSM encodings for the instruction-fetch stage.
// Combinational-free; no latency or backpressure of its own.
package if_fetch_stage_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          INST_LEN_DEF = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/if_pc_gen.sv
// Architectural fetch PC register with hold / +4 / redirect next-PC mux.
// Latency: new PC visible one cycle after advance or redirect.
// Backpressure: none; the PC holds whenever neither select is asserted.
module if_pc_gen
    import if_fetch_stage_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_q
);

    // Redirect outranks the sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_pc;
        end else if (advance) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: one outstanding imem read, buffered word presented to IF/ID.
// Latency: accept at t, response at t+1, if_valid_o at t+2; IF/ID drains via stall_n.
// Backpressure: holds the buffered word while stall_n is low; optional IF_MISALIGN_CHECK_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               INST_LEN = INST_LEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_n,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0]     pc_if_o,
    output logic [INST_LEN-1:0] instr_if_o,
    output logic                if_valid_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                if_misalign_o
`endif
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redir_eff;
    logic            redir_mis;
    logic            stale;
    logic            advance;

`ifdef IF_MISALIGN_CHECK_EN
    logic            mis_pend;
    assign redir_eff = redirect_pc;
    assign redir_mis = |redirect_pc[1:0];
`else
    assign redir_eff = redirect_pc & ~XLEN'(3);
    assign redir_mis = 1'b0;
`endif

    // A redirect here leaves a response still owed by the memory.
    assign stale = ((state == ST_REQ)  && imem_req_ready) ||
                   ((state == ST_WAIT) && !imem_rsp_valid) ||
                   (state == ST_DROP);

    assign advance        = (state == ST_HOLD) && stall_n && !redirect_valid;
    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = pc_q;

    if_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .redirect    (redirect_valid),
        .redirect_pc (redir_eff),
        .pc_q        (pc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc_if_o    <= RESET_PC;
            instr_if_o <= '0;
            if_valid_o <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            if_misalign_o <= 1'b0;
            mis_pend      <= 1'b0;
`endif
        end else if (redirect_valid) begin
            if_valid_o <= 1'b0;
            instr_if_o <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            if_misalign_o <= 1'b0;
            mis_pend      <= redir_mis && stale;
`endif
            if (stale) begin
                state <= ST_DROP;
            end else if (redir_mis) begin
                // Misaligned target: report it through the buffer instead of fetching.
                state      <= ST_HOLD;
                if_valid_o <= 1'b1;
                pc_if_o    <= redir_eff;
`ifdef IF_MISALIGN_CHECK_EN
                if_misalign_o <= 1'b1;
`endif
            end else begin
                state <= ST_REQ;
            end
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (imem_req_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_if_o <= imem_rsp_data;
                        if_valid_o <= 1'b1;
                        pc_if_o    <= pc_q;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stall_n) begin
                        instr_if_o <= '0;
                        if_valid_o <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
                        if_misalign_o <= 1'b0;
`endif
                        state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid) begin
`ifdef IF_MISALIGN_CHECK_EN
                        if (mis_pend) begin
                            state         <= ST_HOLD;
                            if_valid_o    <= 1'b1;
                            pc_if_o       <= pc_q;
                            if_misalign_o <= 1'b1;
                            mis_pend      <= 1'b0;
                        end else
`endif
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, stall hold, redirects in each state.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [63:0] pc_if_o;
    logic [31:0] instr_if_o;
    logic        if_valid_o;
`ifdef IF_MISALIGN_CHECK_EN
    logic        if_misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_n        (stall_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_if_o        (pc_if_o),
        .instr_if_o     (instr_if_o),
        .if_valid_o     (if_valid_o)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .if_misalign_o  (if_misalign_o)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        tick(); tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid_o); end
        total++; if (instr_if_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr_if_o); end
        total++; if (pc_if_o !== 64'h8000_0000) begin bad++; $display("FAIL reset_pc_if got=%h want=80000000", pc_if_o); end
        rst_n = 1'b1;
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
            bad++; $display("FAIL first_req got=%b/%h want=1/80000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        logic [31:0] exp_ins;
        for (int i = 0; i < 3; i++) begin
            exp_pc  = 64'h8000_0000 + 64'(4 * i);
            exp_ins = 32'h0010_0093 + 32'(i);
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                bad++; $display("FAIL stream_req%0d got=%b/%h want=1/%h", i, imem_req_valid, imem_req_addr, exp_pc); end
            imem_req_ready = 1'b1; tick();
            imem_req_ready = 1'b0;
            total++; if (if_valid_o !== 1'b0 || imem_req_valid !== 1'b0) begin
                bad++; $display("FAIL stream_wait%0d got=%b/%b want=0/0", i, if_valid_o, imem_req_valid); end
            imem_rsp_valid = 1'b1; imem_rsp_data = exp_ins; tick();
            imem_rsp_valid = 1'b0;
            total++; if (if_valid_o !== 1'b1 || pc_if_o !== exp_pc || instr_if_o !== exp_ins) begin
                bad++; $display("FAIL stream_out%0d got=%b/%h/%h want=1/%h/%h", i, if_valid_o, pc_if_o, instr_if_o, exp_pc, exp_ins); end
            tick();
        end
    endtask

    task automatic test_hold_stall();
        imem_req_ready = 1'b1; stall_n = 1'b0; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678; tick();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            total++; if (if_valid_o !== 1'b1 || pc_if_o !== 64'h8000_000C || instr_if_o !== 32'h1234_5678 || imem_req_valid !== 1'b0) begin
                bad++; $display("FAIL hold_c%0d got=%b/%h/%h/%b want=1/8000000c/12345678/0", i, if_valid_o, pc_if_o, instr_if_o, imem_req_valid); end
            tick();
        end
        stall_n = 1'b1; tick();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0010 || if_valid_o !== 1'b0) begin
            bad++; $display("FAIL hold_release got=%b/%h/%b want=1/80000010/0", imem_req_valid, imem_req_addr, if_valid_o); end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; tick();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b0 || if_valid_o !== 1'b0) begin
            bad++; $display("FAIL rw_drop got=%b/%b want=0/0", imem_req_valid, if_valid_o); end
        tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_drop_wait got=%b want=0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick();
        imem_rsp_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100 || if_valid_o !== 1'b0 || instr_if_o !== 32'h0) begin
            bad++; $display("FAIL rw_after got=%b/%h/%b/%h want=1/80000100/0/0", imem_req_valid, imem_req_addr, if_valid_o, instr_if_o); end
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; tick();
        imem_rsp_valid = 1'b0;
        total++; if (if_valid_o !== 1'b1 || pc_if_o !== 64'h8000_0100 || instr_if_o !== 32'h0000_0013) begin
            bad++; $display("FAIL rw_target got=%b/%h/%h want=1/80000100/00000013", if_valid_o, pc_if_o, instr_if_o); end
        tick();
    endtask

    task automatic test_redirect_rsp();
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; tick();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
            bad++; $display("FAIL rr_req got=%b/%h want=1/80000200", imem_req_valid, imem_req_addr); end
        total++; if (if_valid_o !== 1'b0 || instr_if_o !== 32'h0) begin
            bad++; $display("FAIL rr_dropped got=%b/%h want=0/0", if_valid_o, instr_if_o); end
    endtask

    task automatic test_req_stall_redirect();
        for (int i = 0; i < 4; i++) begin
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
                bad++; $display("FAIL rs_c%0d got=%b/%h want=1/80000200", i, imem_req_valid, imem_req_addr); end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; tick();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) begin
            bad++; $display("FAIL rs_switch got=%b/%h want=1/80000300", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0030_0313; stall_n = 1'b0; tick();
        imem_rsp_valid = 1'b0;
        total++; if (if_valid_o !== 1'b1 || pc_if_o !== 64'h8000_0300 || instr_if_o !== 32'h0030_0313) begin
            bad++; $display("FAIL rs_target got=%b/%h/%h want=1/80000300/00300313", if_valid_o, pc_if_o, instr_if_o); end
    endtask

`ifdef IF_MISALIGN_CHECK_EN
    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (imem_req_valid !== 1'b0 || if_valid_o !== 1'b1 || if_misalign_o !== 1'b1 || instr_if_o !== 32'h0 || pc_if_o !== 64'h8000_0102) begin
                bad++; $display("FAIL mis_hold%0d got=%b/%b/%b/%h/%h want=0/1/1/0/80000102", i, imem_req_valid, if_valid_o, if_misalign_o, instr_if_o, pc_if_o); end
            tick();
        end
        stall_n = 1'b1; tick();
        total++; if (if_misalign_o !== 1'b0 || if_valid_o !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0106) begin
            bad++; $display("FAIL mis_leave got=%b/%b/%b/%h want=0/0/1/80000106", if_misalign_o, if_valid_o, imem_req_valid, imem_req_addr); end
    endtask
`else
    task automatic test_redirect_align();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0402; tick();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0400 || if_valid_o !== 1'b0) begin
            bad++; $display("FAIL align_req got=%b/%h/%b want=1/80000400/0", imem_req_valid, imem_req_addr, if_valid_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_req_stall_redirect();
`ifdef IF_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_redirect_align();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
